// File: rtl/ex_alu_sequencer.sv
// Execute-stage sequencer: drives an external ALU, builds SLT/SLTU, runs shifts.
// Define EX_BARREL_SHIFT_EN for single-cycle shifts instead of the iterative shifter.
module ex_alu_sequencer (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic        in_is_imm,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] alu_input_a,
    output logic [31:0] alu_input_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_output,
    input  logic        alu_neg,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  f3_q, f3_d;
    logic        f7_q, f7_d;
    logic        imm_q, imm_d;
    logic [31:0] res_q, res_d;
    logic        sign_diff;
    logic        lt;
    logic        unused_flags;

`ifndef EX_BARREL_SHIFT_EN
    logic [31:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] sh_next;
`else
    logic [31:0] barrel;
`endif

    assign unused_flags = alu_zero;
    assign in_ready     = (state_q == IDLE) && !reset_in;
    assign out_valid    = (state_q == DONE);
    assign out_result   = res_q;
    assign alu_input_a  = a_q;
    assign alu_input_b  = b_q;

    // Opposite signs decide the compare directly; otherwise the subtract sign does.
    assign sign_diff = a_q[31] ^ b_q[31];
    assign lt = sign_diff ? (f3_q[0] ? b_q[31] : a_q[31]) : alu_neg;

`ifndef EX_BARREL_SHIFT_EN
    always_comb begin
        sh_next = sh_q;
        if (f3_q[2])
            sh_next = {f7_q & sh_q[31], sh_q[31:1]};
        else
            sh_next = {sh_q[30:0], 1'b0};
    end
`else
    always_comb begin
        barrel = a_q;
        if (!f3_q[2])
            barrel = a_q << b_q[4:0];
        else if (f7_q)
            barrel = 32'($signed(a_q) >>> b_q[4:0]);
        else
            barrel = a_q >> b_q[4:0];
    end
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        f3_d       = f3_q;
        f7_d       = f7_q;
        imm_d      = imm_q;
        res_d      = res_q;
        alu_opcode = 4'b0000;
`ifndef EX_BARREL_SHIFT_EN
        sh_d       = sh_q;
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_rs1;
                    b_d     = in_rs2_imm;
                    f3_d    = in_funct3;
                    f7_d    = in_funct7b5;
                    imm_d   = in_is_imm;
                    state_d = EXEC;
`ifndef EX_BARREL_SHIFT_EN
                    if (in_funct3[1:0] == 2'b01) begin
                        sh_d  = in_rs1;
                        cnt_d = in_rs2_imm[4:0];
                        if (in_rs2_imm[4:0] == 5'd0) begin
                            res_d   = in_rs1;
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
`endif
                end
            end
            EXEC: begin
                res_d   = alu_output;
                state_d = DONE;
                case (f3_q)
                    3'b000:  alu_opcode = (f7_q && !imm_q) ? 4'b1000 : 4'b0000;
                    3'b100:  alu_opcode = 4'b0100;
                    3'b110:  alu_opcode = 4'b0110;
                    3'b111:  alu_opcode = 4'b0111;
                    3'b010,
                    3'b011: begin
                        alu_opcode = 4'b1000;
                        res_d      = {31'b0, lt};
                    end
`ifdef EX_BARREL_SHIFT_EN
                    default: res_d = barrel;
`else
                    default: alu_opcode = 4'b0000;
`endif
                endcase
            end
            SHIFT: begin
`ifndef EX_BARREL_SHIFT_EN
                sh_d  = sh_next;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    res_d   = sh_next;
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            f7_q    <= 1'b0;
            imm_q   <= 1'b0;
            res_q   <= '0;
`ifndef EX_BARREL_SHIFT_EN
            sh_q    <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
`ifndef EX_BARREL_SHIFT_EN
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Directed bench for ex_alu_sequencer with a behavioural ALU attached.
module tb_ex_alu_sequencer;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic        in_is_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] alu_input_a;
    logic [31:0] alu_input_b;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_output;
    logic        alu_neg;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    ex_alu_sequencer dut (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_is_imm   (in_is_imm),
        .in_rs1      (in_rs1),
        .in_rs2_imm  (in_rs2_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .alu_input_a (alu_input_a),
        .alu_input_b (alu_input_b),
        .alu_opcode  (alu_opcode),
        .alu_output  (alu_output),
        .alu_neg     (alu_neg),
        .alu_zero    (alu_zero)
    );

    always #5 clock_in = ~clock_in;

    // External ALU
    always_comb begin
        alu_output = 32'h0;
        case (alu_opcode)
            4'b0000: alu_output = alu_input_a + alu_input_b;
            4'b0100: alu_output = alu_input_a ^ alu_input_b;
            4'b0110: alu_output = alu_input_a | alu_input_b;
            4'b0111: alu_output = alu_input_a & alu_input_b;
            4'b1000: alu_output = alu_input_a - alu_input_b;
            default: alu_output = 32'h0;
        endcase
    end
    assign alu_neg  = alu_output[31];
    assign alu_zero = (alu_output == 32'h0);

`ifdef EX_BARREL_SHIFT_EN
    function automatic int sh_lat(input int n);
        return 1;
    endfunction
`else
    function automatic int sh_lat(input int n);
        return n;
    endfunction
`endif

    // Drive one request from a negedge; return at the negedge where out_valid is seen.
    task automatic issue(input logic [2:0] f3, input logic f7, input logic imm,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic rdy, output logic [3:0] opc, output int lat);
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_is_imm   = imm;
        in_rs1      = a;
        in_rs2_imm  = b;
        in_valid    = 1'b1;
        rdy         = in_ready;
        @(posedge clock_in);
        @(negedge clock_in);
        in_valid   = 1'b0;
        in_funct3  = 3'b111;
        in_rs1     = 32'hDEAD_BEEF;
        in_rs2_imm = 32'h1234_5678;
        opc = alu_opcode;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clock_in);
            @(negedge clock_in);
            lat++;
        end
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        @(posedge clock_in);
        @(negedge clock_in);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_in = 1'b1;
        repeat (2) @(posedge clock_in);
        @(negedge clock_in);
        total++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset: valid=%b result=%h ready=%b want 0/0/0",
                     out_valid, out_result, in_ready);
        end
        reset_in = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
        @(negedge clock_in);
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic f7,
                          input logic imm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input logic [3:0] exp_opc);
        logic rdy;
        logic [3:0] opc;
        int lat;
        issue(f3, f7, imm, a, b, rdy, opc, lat);
        total++;
        if (rdy !== 1'b1 || out_result !== exp_res || lat != exp_lat || opc !== exp_opc) begin
            bad++;
            $display("FAIL %s: ready=%b result=%h lat=%0d opc=%b want 1/%h/%0d/%b",
                     name, rdy, out_result, lat, opc, exp_res, exp_lat, exp_opc);
        end
        release_result();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_handoff: valid=%b ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_add_sub;
        run_op("add",  3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1, 4'b0000);
        run_op("sub",  3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 4'b1000);
        run_op("addi", 3'b000, 1'b1, 1'b1, 32'd3, 32'd5, 32'd8, 1, 4'b0000);
        run_op("wrap", 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1, 4'b0000);
    endtask

    task automatic test_logic;
        run_op("xor", 3'b100, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1, 4'b0100);
        run_op("or",  3'b110, 1'b0, 1'b1, 32'hA000_0005, 32'h0000_0030, 32'hA000_0035, 1, 4'b0110);
        run_op("and", 3'b111, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 4'b0111);
    endtask

    task automatic test_slt;
        run_op("slt_neg",   3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 4'b1000);
        run_op("sltu_big",  3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 4'b1000);
        run_op("slt_ovf",   3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1, 4'b1000);
        run_op("sltu_ovf",  3'b011, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1, 4'b1000);
        run_op("sltu_same", 3'b011, 1'b0, 1'b1, 32'd4, 32'd9, 32'd1, 1, 4'b1000);
        run_op("slt_eq",    3'b010, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1, 4'b1000);
    endtask

    task automatic test_shift;
        run_op("sra",  3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, sh_lat(4), 4'b0000);
        run_op("srl",  3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, sh_lat(4), 4'b0000);
        run_op("sll",  3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'd31, 32'h8000_0000, sh_lat(31), 4'b0000);
        run_op("srai", 3'b101, 1'b1, 1'b1, 32'h9000_0010, 32'h0000_0402, 32'hE400_0004, sh_lat(2), 4'b0000);
        run_op("sll1", 3'b001, 1'b0, 1'b1, 32'h4000_0003, 32'd1, 32'h8000_0006, sh_lat(1), 4'b0000);
`ifdef EX_BARREL_SHIFT_EN
        run_op("sh0",  3'b101, 1'b1, 1'b0, 32'h8765_4321, 32'h0000_0020, 32'h8765_4321, 1, 4'b0000);
`else
        run_op("sh0",  3'b101, 1'b1, 1'b0, 32'h8765_4321, 32'h0000_0020, 32'h8765_4321, 0, 4'b0000);
`endif
    endtask

    task automatic test_backpressure;
        logic rdy;
        logic [3:0] opc;
        int lat;
        issue(3'b000, 1'b0, 1'b0, 32'd100, 32'd23, rdy, opc, lat);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_in);
            @(negedge clock_in);
            total++;
            if (out_valid !== 1'b1 || out_result !== 32'd123 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: valid=%b result=%h ready=%b want 1/%h/0",
                         i, out_valid, out_result, in_ready, 32'd123);
            end
        end
        release_result();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd123) begin
            bad++;
            $display("FAIL stall_release: valid=%b ready=%b result=%h want 0/1/%h",
                     out_valid, in_ready, out_result, 32'd123);
        end
    endtask

    task automatic test_reset_mid_shift;
        in_funct3   = 3'b001;
        in_funct7b5 = 1'b0;
        in_is_imm   = 1'b1;
        in_rs1      = 32'h0000_0001;
        in_rs2_imm  = 32'd10;
        in_valid    = 1'b1;
        @(posedge clock_in);
        @(negedge clock_in);
        in_valid = 1'b0;
        @(posedge clock_in);
        @(negedge clock_in);
        reset_in = 1'b1;
        @(posedge clock_in);
        @(negedge clock_in);
        reset_in = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        repeat (12) @(posedge clock_in);
        @(negedge clock_in);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_quiet: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        run_op("add_after_reset", 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1, 4'b0000);
    endtask

    task automatic test_back_to_back;
        run_op("b2b_a", 3'b100, 1'b0, 1'b1, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1, 4'b0100);
        run_op("b2b_b", 3'b000, 1'b1, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, 4'b1000);
    endtask

    initial begin
        reset_in    = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_funct3   = 3'b000;
        in_funct7b5 = 1'b0;
        in_is_imm   = 1'b0;
        in_rs1      = 32'h0;
        in_rs2_imm  = 32'h0;
        @(negedge clock_in);
        test_reset();
        test_add_sub();
        test_logic();
        test_slt();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
